// File: rtl/icache_dm_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
// XLEN normally comes from isa.v; the fallback keeps this slice self-contained.
`ifndef XLEN
`define XLEN 32
`endif

package icache_dm_pkg;

  localparam int unsigned ICACHE_LINE_WORDS  = 4;
  localparam int unsigned ICACHE_OFFSET_BITS = 4;

  typedef enum logic {
    StLookup = 1'b0,
    StRefill = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_data_array.sv
// Cache line word storage: combinational read, one synchronous word write per cycle.
module icache_data_array
  import icache_dm_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned XLEN      = 32
) (
  input  logic                         clk,
  input  logic [$clog2(NUM_LINES)-1:0] rd_idx_i,
  input  logic [1:0]                   rd_word_i,
  output logic [XLEN-1:0]              rd_data_o,
  input  logic                         wr_en_i,
  input  logic [$clog2(NUM_LINES)-1:0] wr_idx_i,
  input  logic [1:0]                   wr_word_i,
  input  logic [XLEN-1:0]              wr_data_i
);

  logic [XLEN-1:0] mem_q [NUM_LINES][ICACHE_LINE_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i][wr_word_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i][rd_word_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency hits, one-cycle miss pulse, 4-beat refill.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned XLEN      = `XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            stall,
  output logic            cache_miss,
  output logic [XLEN-1:0] miss_addr,
  input  logic            refill_valid,
  input  logic [XLEN-1:0] refill_data,
  input  logic            refill_done
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = XLEN - ICACHE_OFFSET_BITS - IDX_W;

  icache_state_e         state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q [NUM_LINES];
  logic [1:0]            cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic                  cache_miss_q, cache_miss_d;
  logic [XLEN-1:0]       miss_addr_q, miss_addr_d;

  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic [1:0]       req_off, wr_word;
  logic             hit, wr_en, tag_we;
  logic             unused_addr_bits;

  assign req_idx  = req_addr[ICACHE_OFFSET_BITS +: IDX_W];
  assign req_tag  = req_addr[XLEN-1 -: TAG_W];
  assign req_off  = req_addr[3:2];
  assign miss_idx = miss_addr_q[ICACHE_OFFSET_BITS +: IDX_W];
  assign miss_tag = miss_addr_q[XLEN-1 -: TAG_W];
  assign unused_addr_bits = ^{req_addr[1:0], miss_addr_q[ICACHE_OFFSET_BITS-1:0]};

  assign hit = (state_q == StLookup) && req_valid && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag) && !flush;

  assign resp_valid = hit;
  assign stall      = (req_valid && !hit) || (state_q != StLookup);
  assign cache_miss = cache_miss_q;
  assign miss_addr  = miss_addr_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    cache_miss_d = 1'b0;
    miss_addr_d  = miss_addr_q;
    wr_en        = 1'b0;
    wr_word      = cnt_q;
    tag_we       = 1'b0;
    unique case (state_q)
      StLookup: begin
        if (req_valid && !hit && !flush) begin
          cache_miss_d     = 1'b1;
          miss_addr_d      = {req_addr[XLEN-1:ICACHE_OFFSET_BITS], {ICACHE_OFFSET_BITS{1'b0}}};
          cnt_d            = 2'd0;
          // Victim goes invalid now so a half-filled line can never hit.
          valid_d[req_idx] = 1'b0;
          state_d          = StRefill;
        end
      end
      StRefill: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        if (refill_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 2'd1;
        end else if (refill_done) begin
          wr_en             = 1'b1;
          wr_word           = 2'd3;
          tag_we            = 1'b1;
          valid_d[miss_idx] = !drop_q;
          drop_d            = 1'b0;
          state_d           = StLookup;
        end
      end
      default: state_d = StLookup;
    endcase
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StLookup;
      valid_q      <= '0;
      cnt_q        <= 2'd0;
      drop_q       <= 1'b0;
      cache_miss_q <= 1'b0;
      miss_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      cache_miss_q <= cache_miss_d;
      miss_addr_q  <= miss_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[miss_idx] <= miss_tag;
    end
  end

  icache_data_array #(
    .NUM_LINES (NUM_LINES),
    .XLEN      (XLEN)
  ) u_data (
    .clk       (clk),
    .rd_idx_i  (req_idx),
    .rd_word_i (req_off),
    .rd_data_o (resp_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (miss_idx),
    .wr_word_i (wr_word),
    .wr_data_i (refill_data)
  );

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (resp_valid && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (cache_miss_q && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  // Refill protocol: beats and the final word are exclusive, and done follows three beats.
  a_beat_excl : assert property (@(posedge clk) disable iff (reset)
    !(refill_valid && refill_done));
  a_done_after_three : assert property (@(posedge clk) disable iff (reset)
    (state_q == StRefill && refill_done) |-> (cnt_q == 2'd3));

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm: misses, hits, eviction, flush and reset.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        stall;
  logic        cache_miss;
  logic [31:0] miss_addr;
  logic        refill_valid;
  logic [31:0] refill_data;
  logic        refill_done;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  icache_dm #(
    .NUM_LINES (16),
    .XLEN      (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .stall        (stall),
    .cache_miss   (cache_miss),
    .miss_addr    (miss_addr),
    .refill_valid (refill_valid),
    .refill_data  (refill_data),
    .refill_done  (refill_done)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a missing address, check no hit, then check the one-cycle miss pulse.
  task automatic expect_miss(input logic [31:0] addr, input logic [31:0] line);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    chk("miss_no_hit", {31'd0, resp_valid}, 32'd0);
    chk("miss_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("miss_pulse", {31'd0, cache_miss}, 32'd1);
    chk("miss_addr", miss_addr, line);
    chk("refill_stall", {31'd0, stall}, 32'd1);
  endtask

  task automatic do_refill(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 3; i++) begin
      refill_valid = 1'b1;
      refill_data  = w[i];
      tick();
      chk("no_remiss", {31'd0, cache_miss}, 32'd0);
      chk("refill_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    refill_valid = 1'b0;
    refill_done  = 1'b1;
    refill_data  = w[3];
    tick();
    refill_done  = 1'b0;
    refill_data  = 32'd0;
  endtask

  task automatic expect_hit(input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    chk("hit_valid", {31'd0, resp_valid}, 32'd1);
    chk("hit_data", resp_data, data);
    chk("hit_no_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("hit_no_miss", {31'd0, cache_miss}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 32'd0;
    flush        = 1'b0;
    refill_valid = 1'b0;
    refill_data  = 32'd0;
    refill_done  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_cache_miss", {31'd0, cache_miss}, 32'd0);
    chk("rst_miss_addr", miss_addr, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Cold miss, refill, then hit on word 1.
    expect_miss(32'h0000_0104, 32'h0000_0100);
    do_refill(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    expect_hit(32'h0000_0104, 32'hA1);

    // Hit sweep across the line.
    expect_hit(32'h0000_0100, 32'hA0);
    expect_hit(32'h0000_0108, 32'hA2);
    expect_hit(32'h0000_010C, 32'hA3);
`ifdef ICACHE_STATS_EN
    chk("stat_miss_count", miss_count, 32'd1);
    chk("stat_hit_count", hit_count, 32'd4);
`endif

    // Conflict eviction on index 0.
    expect_miss(32'h0000_0204, 32'h0000_0200);
    do_refill(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    expect_hit(32'h0000_0204, 32'hB1);
    expect_miss(32'h0000_0104, 32'h0000_0100);
    do_refill(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    expect_hit(32'h0000_0104, 32'hA1);

    // Flush in LOOKUP: no hit, no launch, then the line misses.
    flush = 1'b1;
    #1;
    chk("flush_no_hit", {31'd0, resp_valid}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_no_launch", {31'd0, cache_miss}, 32'd0);
    expect_miss(32'h0000_0104, 32'h0000_0100);

    // Flush during REFILL: the completed line must stay invalid.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_refill(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    #1;
    chk("drop_no_hit", {31'd0, resp_valid}, 32'd0);
    chk("drop_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("drop_remiss", {31'd0, cache_miss}, 32'd1);
    chk("drop_remiss_addr", miss_addr, 32'h0000_0100);
    do_refill(32'hE0, 32'hE1, 32'hE2, 32'hE3);
    expect_hit(32'h0000_0104, 32'hE1);

    // Reset after two refill beats.
    expect_miss(32'h0000_0304, 32'h0000_0300);
    refill_valid = 1'b1;
    refill_data  = 32'hC0;
    tick();
    refill_data  = 32'hC1;
    tick();
    refill_valid = 1'b0;
    refill_data  = 32'd0;
    reset = 1'b1;
    #1;
    chk("midrst_cache_miss", {31'd0, cache_miss}, 32'd0);
    chk("midrst_miss_addr", miss_addr, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    reset = 1'b0;
    req_addr = 32'h0000_0104;
    #1;
    chk("midrst_old_line_gone", {31'd0, resp_valid}, 32'd0);
    expect_miss(32'h0000_0304, 32'h0000_0300);
    do_refill(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    expect_hit(32'h0000_0308, 32'hC2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache between the fetch stage and the cache refill controller.
- Serves fetch requests on hits in the same cycle.
- On a miss it raises a one-cycle miss request with a line-aligned address to the refill controller, then absorbs the 4-word refill stream into the indexed line.
- Lines are 16 bytes (4 x 32-bit words). Valid bits are cleared by reset or flush (fence.i).

Parameters:
- NUM_LINES, 16, number of lines; must be a power of 2 and at least 2; IDX_W = log2(NUM_LINES).
- XLEN, `XLEN (32), data/address width taken from isa.v.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  fetch request valid.
- req_addr  in  XLEN  fetch byte address; bits [1:0] ignored.
- flush  in  1  invalidate all lines (fence.i).
- resp_valid  out  1  hit; resp_data is valid this cycle.
- resp_data  out  XLEN  instruction word.
- stall  out  1  fetch must hold req_addr.
- cache_miss  out  1  one-cycle miss pulse to the refill controller.
- miss_addr  out  XLEN  line-aligned miss address: {req_addr[XLEN-1:4],4'b0}.
- refill_valid  in  1  refill beat; refill_data holds words 0..2 in order.
- refill_data  in  XLEN  refill word.
- refill_done  in  1  final beat; refill_data holds word 3 in this cycle, and refill_valid is low.

Behaviour:
- Address split: offset = addr[3:2]; index = addr[4+IDX_W-1:4]; tag = addr[XLEN-1:4+IDX_W].
- Storage: valid[NUM_LINES], tag[NUM_LINES], data[NUM_LINES][4]. Combinational read, synchronous write.
- Reset values:
  - state = LOOKUP.
  - All valid bits = 0.
  - cache_miss = 0, miss_addr = 0, refill word counter = 0, drop flag = 0.
  - resp_valid = 0 (combinational, follows state).
- States:
  - LOOKUP:
    - hit = req_valid & valid[index] & tag match & !flush.
    - resp_valid = hit; resp_data = data[index][offset]; zero latency.
    - If req_valid and not hit and not flush: register cache_miss <= 1 and miss_addr <= line-aligned req_addr, clear counter, go to REFILL.
  - REFILL:
    - cache_miss <= 0, so it is high for exactly one cycle. It must not be re-asserted while the refill is in progress.
    - Each refill_valid: data[miss index][cnt] <= refill_data; cnt++ (2-bit).
    - refill_done: data[miss index][3] <= refill_data; tag <= miss tag; valid <= !drop; clear drop; go to LOOKUP.
    - The request repeats the lookup the following cycle and hits, unless the line was dropped.
- stall = (req_valid & !hit) | (state != LOOKUP).
- resp_valid = 0 in REFILL.
- Beat order boundary: refill_valid and refill_done never coincide. If refill_done arrives with cnt != 3, the line is still installed using word 3 from refill_data; this is a protocol error and an assertion flags it.
- Flush:
  - Clears all valid bits next edge.
  - No hit in a flush cycle and no miss launch in that cycle.
  - Flush in REFILL sets drop. The refill still completes and writes data/tag, but the line stays invalid, so stale pre-fence data is never hit.
- Simultaneous refill_done and flush: line not validated; valids cleared.
- Reset mid-refill: immediate return to LOOKUP with all lines invalid. The refill controller shares reset.
- Miss on an index holding a valid line: the line is invalidated at REFILL entry, so a partially filled line is never hit.

Optional Feature:
- ICACHE_STATS_EN:
  - Defined: adds outputs hit_count and miss_count, both 32-bit.
  - hit_count increments on each resp_valid cycle. miss_count increments on each cache_miss pulse.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
  - Undefined: ports and counters are absent.

Decomposition:
- Shared package/include (next to isa.v) holds:
  - ICACHE_LINE_WORDS = 4.
  - ICACHE_OFFSET_BITS = 4.
  - State encodings LOOKUP = 1'b0 and REFILL = 1'b1.
- One sub-module, icache_data_array:
  - NUM_LINES x 4 word storage with a combinational read port and a per-word write port (index, word select, write enable, data).
  - Tags and valids stay in icache_dm.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, req_addr=0x0000_0104.
   - Required: cache_miss pulses 1 cycle with miss_addr=0x0000_0100; stall high.
   - Stimulus: feed 0xA0,0xA1,0xA2 on refill_valid, then 0xA3 with refill_done.
   - Required: next cycle resp_valid=1, resp_data=0xA1.
2. Hit sweep:
   - Stimulus: after test 1, req_addr=0x100/0x108/0x10C.
   - Required: resp_valid in the same cycle with 0xA0/0xA2/0xA3; no cache_miss.
3. Conflict eviction:
   - Stimulus: req_addr=0x0000_0204 (same index 0, tag differs); refill B0..B3.
   - Required: resp_data=0xB1. Then 0x104 misses again with miss_addr=0x100.
4. Flush:
   - Stimulus: after a fill, assert flush one cycle.
   - Required: next request to the same address misses.
   - Stimulus: flush asserted mid-REFILL.
   - Required: after refill_done, the same address misses again (drop honoured).
5. Reset mid-refill:
   - Stimulus: assert reset after two refill beats.
   - Required: all outputs at reset values; the subsequent request misses; no stale partial line hits.
6. ICACHE_STATS_EN:
   - Stimulus: scenarios 1+2.
   - Required: miss_count=1, hit_count=4 (1 post-refill + 3 sweep).
